gcd_accel: RTL and testbench
============================

# gcd_accel

Parametrised Avalon-MM GCD accelerator. It is the successor to the team's fixed 32-bit sequential GCD slave and sits on the HPS lightweight bridge in `Computer_System`. Operands are double-buffered, and a computation runs only on an explicit start command. Zero operands, abort, an iteration counter and an optional interrupt all have defined behaviour; nothing in this block hangs.

## Interface
Parameters:
- `WIDTH`, default 32: operand width, legal range 8..32. Bus writes are truncated to `WIDTH`; reads are zero-extended to 32 bits.

Ports:
- `csi_clk`, in, 1: single clock.
- `rsi_reset`, in, 1: synchronous, active-high reset.
- `avs_s0_address`, in, 3: word address.
- `avs_s0_read`, in, 1: read strobe.
- `avs_s0_write`, in, 1: write strobe.
- `avs_s0_writedata`, in, 32: write data.
- `avs_s0_readdata`, out, 32: registered read data; read latency is 1.
- `ins_irq`, out, 1: interrupt, level, active-high. Present only with `GCD_ACCEL_IRQ_EN`.

## Operation
Address map:
- 0 `A`: R/W operand shadow.
- 1 `B`: R/W operand shadow.
- 2 `RESULT`: read-only.
- 3 write `CTRL`: bit0 start, bit1 irq_en, bit2 clear_done, bit3 abort.
- 3 read `STATUS`: bit0 done, bit1 busy, bit2 zero_err, bit3 irq_en.
- 4 `COUNT`: read-only, number of subtractions in the last run.
- 5..7: read 0; writes ignored.

Behaviour:
- Shadow registers `A`/`B` are writable at any time. Writes during busy affect the next run only.
- FSM states are `IDLE`, `RUN`, `DONE`.
- Start while in `IDLE` or `DONE`:
  - latch `a_r` ← `A`, `b_r` ← `B`;
  - clear `cnt`, done and zero_err;
  - set zero_err if `A` = `B` = 0;
  - go to `RUN`.
- Start while in `RUN`: ignored.
- Each `RUN` cycle:
  - if `a_r` = 0, `b_r` = 0, or `a_r` = `b_r`: `RESULT` ← `a_r | b_r`, `COUNT` ← `cnt`, go to `DONE`;
  - else if `a_r` > `b_r`: `a_r` ← `a_r` − `b_r`;
  - else: `b_r` ← `b_r` − `a_r`.
  - `cnt` increments on every subtraction. `cnt` is `WIDTH` bits; the worst case is 2^WIDTH − 2, so it never wraps.
- The OR rule yields gcd(x,0) = x and gcd(0,0) = 0.
- Abort while in `RUN`: go to `IDLE`. `RESULT`, `COUNT` and done are unchanged.
- Abort while not in `RUN`: no effect.
- Done clears on any of: clear_done write, a read of `RESULT`, or a new start. Clearing done moves `DONE` → `IDLE`.
- Simultaneous events:
  - start and abort in the same write: abort wins if in `RUN`; otherwise start proceeds.
  - start and clear_done in the same write: start wins.
- irq_en is written on every `CTRL` write.
- Reset: FSM → `IDLE`. `A`, `B`, `a_r`, `b_r`, `RESULT`, `COUNT`, done, zero_err, irq_en and `cnt` all go to 0. `avs_s0_readdata` = 0 and `ins_irq` = 0.
- Reset during `RUN` discards the run. No done is produced.

## Timing
- The start write is sampled at edge T. `busy` is readable from T+1.
- With N subtractions, the `RUN` cycles occupy edges T+1..T+N+1. done, `RESULT` and `COUNT` update at edge T+N+1. Total latency is N+1 cycles after the start edge.
- Read: address sampled at edge R, data valid on `avs_s0_readdata` after edge R, so it is usable at R+1. `avs_s0_readdata` holds its value between reads.
- A `RESULT` read at edge R clears done at edge R. The read still returns the result.
- No waitrequest; every access completes in one cycle.

## Configuration
- `GCD_ACCEL_IRQ_EN` defined:
  - `ins_irq` port exists;
  - `ins_irq` = done & irq_en, registered, asserted from edge T+N+1;
  - `ins_irq` deasserts the cycle after done clears.
- Undefined:
  - no `ins_irq` port;
  - `CTRL` bit1 and `STATUS` bit3 read 0;
  - software polls `STATUS`.

## Structure
- Package `gcd_accel_pkg` holds:
  - address constants `ADDR_A`..`ADDR_COUNT`;
  - `CTRL`/`STATUS` bit-index constants;
  - FSM enum `gcd_state_t` (`IDLE`, `RUN`, `DONE`).
- Sub-module `gcd_core`, parametrised by `WIDTH`:
  - contains the FSM, `a_r`/`b_r`, the subtractor, and `cnt`;
  - handshake is start/abort/clear in, busy/done/result/count/zero_err out.
- Top level `gcd_accel` holds the shadow registers, address decode, read mux and IRQ logic.

## Test plan
- `A`=12, `B`=8, start at T → busy at T+1; `STATUS`=0x1, `RESULT`=4, `COUNT`=2 after edge T+3.
- `A`=0, `B`=9, start → `RESULT`=9, `COUNT`=0, done after 1 cycle, zero_err=0. `A`=`B`=0 → `RESULT`=0, zero_err=1.
- `A`=255, `B`=1, `WIDTH`=8 → `COUNT`=254, `RESULT`=1. During the run: a second start is ignored, and `A`=6, `B`=4 are written. A restart after done gives `RESULT`=2.
- `A`=1000, `B`=1 → abort after 5 cycles. Result: `IDLE`, done=0, previous `RESULT` and `COUNT` kept. Assert `rsi_reset` mid-run → all registers 0 and no done.
- `RESULT` read clears done. Start and clear_done in the same write → run proceeds.
- With `GCD_ACCEL_IRQ_EN`, irq_en=1, gcd(21,14) → `ins_irq` rises with done, falls after the `RESULT` read. With irq_en=0, `ins_irq` stays 0. Built without the macro, `STATUS` bit3 reads 0.

Source files
------------

// File: rtl/gcd_accel_pkg.sv
// gcd_accel_pkg: register map, control/status bit positions and FSM states for gcd_accel
package gcd_accel_pkg;

    localparam logic [2:0] ADDR_A      = 3'd0;
    localparam logic [2:0] ADDR_B      = 3'd1;
    localparam logic [2:0] ADDR_RESULT = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_COUNT  = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_ZERO_ERR = 2;
    localparam int ST_IRQ_EN   = 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} gcd_state_t;

endpackage

// File: rtl/gcd_accel_if.sv
// gcd_accel_if: Avalon-MM slave bus (address/read/write/writedata/readdata) for gcd_accel
interface gcd_accel_if;

    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/gcd_core.sv
// gcd_core: subtractive GCD engine with start/abort/clear control and subtraction counter
module gcd_core
    import gcd_accel_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             clear,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             zero_err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] count
);

    gcd_state_t       state_q;
    logic [WIDTH-1:0] a_q, b_q, cnt_q, result_q, count_q;
    logic             zero_err_q;

    // Run FSM: latch operands on start, subtract the smaller from the larger until one is zero or both match
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            count_q    <= '0;
            zero_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        cnt_q      <= '0;
                        zero_err_q <= (a_in == '0) && (b_in == '0);
                        state_q    <= RUN;
                    end else if (clear) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (a_q == '0 || b_q == '0 || a_q == b_q) begin
                        result_q <= a_q | b_q;
                        count_q  <= cnt_q;
                        state_q  <= DONE;
                    end else if (a_q > b_q) begin
                        a_q   <= a_q - b_q;
                        cnt_q <= cnt_q + WIDTH'(1);
                    end else begin
                        b_q   <= b_q - a_q;
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign zero_err = zero_err_q;
    assign result   = result_q;
    assign count    = count_q;

endmodule

// File: rtl/gcd_accel.sv
// gcd_accel: Avalon-MM GCD accelerator top; optional level interrupt enabled by GCD_ACCEL_IRQ_EN
module gcd_accel
    import gcd_accel_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       csi_clk,
    input  logic       rsi_reset,
    gcd_accel_if.slave s0
`ifdef GCD_ACCEL_IRQ_EN
    ,
    output logic       ins_irq
`endif
);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result, count;
    logic [31:0]      rdata_q, rdata_d, status;
    logic             busy, done, zero_err, irq_en;
    logic             wr_ctrl, start, abort, clear;

    assign wr_ctrl = s0.write && s0.address == ADDR_CTRL;
    assign start   = wr_ctrl && s0.writedata[CTRL_START];
    assign abort   = wr_ctrl && s0.writedata[CTRL_ABORT];
    // Reading RESULT acknowledges the completion just like an explicit clear_done
    assign clear   = (wr_ctrl && s0.writedata[CTRL_CLEAR]) || (s0.read && s0.address == ADDR_RESULT);

    gcd_core #(.WIDTH(WIDTH)) u_core (
        .clk      (csi_clk),
        .rst      (rsi_reset),
        .start    (start),
        .abort    (abort),
        .clear    (clear),
        .a_in     (a_q),
        .b_in     (b_q),
        .busy     (busy),
        .done     (done),
        .zero_err (zero_err),
        .result   (result),
        .count    (count)
    );

`ifdef GCD_ACCEL_IRQ_EN
    logic irq_en_q, irq_en_d;

    // irq_en follows bit1 of every CTRL write
    always_comb irq_en_d = wr_ctrl ? s0.writedata[CTRL_IRQ_EN] : irq_en_q;

    // Interrupt enable register
    always_ff @(posedge csi_clk) irq_en_q <= rsi_reset ? 1'b0 : irq_en_d;

    assign irq_en  = irq_en_q;
    assign ins_irq = done & irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    // Shadow operand writes and registered read mux; readdata holds between reads
    always_comb begin
        a_d = (s0.write && s0.address == ADDR_A) ? WIDTH'(s0.writedata) : a_q;
        b_d = (s0.write && s0.address == ADDR_B) ? WIDTH'(s0.writedata) : b_q;
        status = '0;
        status[ST_DONE]     = done;
        status[ST_BUSY]     = busy;
        status[ST_ZERO_ERR] = zero_err;
        status[ST_IRQ_EN]   = irq_en;
        rdata_d = !s0.read                  ? rdata_q     :
                  s0.address == ADDR_A      ? 32'(a_q)    :
                  s0.address == ADDR_B      ? 32'(b_q)    :
                  s0.address == ADDR_RESULT ? 32'(result) :
                  s0.address == ADDR_STATUS ? status      :
                  s0.address == ADDR_COUNT  ? 32'(count)  : '0;
    end

    // Shadow operand and read data registers
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            rdata_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            rdata_q <= rdata_d;
        end
    end

    assign s0.readdata = rdata_q;

endmodule

// File: tb/tb_gcd_accel.sv
// tb_gcd_accel: randomized self-checking bench for gcd_accel (WIDTH=8) against an Euclid-quotient model
module tb_gcd_accel;
    import gcd_accel_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gcd_accel_if bus ();

`ifdef GCD_ACCEL_IRQ_EN
    logic irq;
    gcd_accel #(.WIDTH(W)) dut (.csi_clk(clk), .rsi_reset(rst), .s0(bus), .ins_irq(irq));
`else
    gcd_accel #(.WIDTH(W)) dut (.csi_clk(clk), .rsi_reset(rst), .s0(bus));
`endif

    // gcd by the modulo algorithm; subtraction count = sum of quotients, one fewer on the final exact division
    function automatic void model(input int unsigned a, input int unsigned b,
                                  output int unsigned g, output int unsigned n);
        int unsigned x, y, t;
        x = a % (1 << W);
        y = b % (1 << W);
        n = 0;
        g = x | y;
        if (x != 0 && y != 0) begin
            if (x < y) begin t = x; x = y; y = t; end
            while (x % y != 0) begin
                n += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            n += x / y - 1;
            g = y;
        end
    endfunction

    // Each bus op is called at a negedge and returns at the next negedge (one cycle)
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address = addr; bus.writedata = data; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.address = addr; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        data = bus.readdata;
    endtask

    task automatic poll_done(output int polls, output logic [31:0] st);
        polls = 0;
        do begin
            bus_read(ADDR_STATUS, st);
            polls++;
        end while (!st[0] && polls < 1000);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        n_checks++;
        if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata got %h exp 0", bus.readdata); end
`ifdef GCD_ACCEL_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
`endif
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            n_checks++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d got %h exp 0", a, d); end
        end
    endtask

    task automatic test_map;
        logic [31:0] d;
        bus_write(ADDR_A, 32'h0000_01FF);
        bus_read(ADDR_A, d);
        n_checks++;
        if (d !== 32'hFF) begin n_fail++; $display("FAIL trunc_a got %h exp ff", d); end
        bus_write(3'd5, 32'hFFFF_FFFF);
        for (int a = 5; a < 8; a++) begin
            bus_read(3'(a), d);
            n_checks++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped%0d got %h exp 0", a, d); end
        end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        bus_write(ADDR_A, 12);
        bus_write(ADDR_B, 8);
        bus_write(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            bus_read(ADDR_STATUS, d);
            n_checks++;
            if (d !== (k < 4 ? 32'h2 : 32'h1)) begin n_fail++; $display("FAIL basic_status_k%0d got %h exp %h", k, d, k < 4 ? 2 : 1); end
        end
        bus_read(ADDR_COUNT, d);
        n_checks++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL basic_count got %0d exp 2", d); end
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== 32'd4) begin n_fail++; $display("FAIL basic_result got %0d exp 4", d); end
    endtask

    task automatic test_zero;
        logic [31:0] d;
        int polls;
        bus_write(ADDR_A, 0);
        bus_write(ADDR_B, 9);
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        n_checks++;
        if (polls != 2 || d !== 32'h1) begin n_fail++; $display("FAIL zero_b_status got %h polls %0d exp 1 polls 2", d, polls); end
        bus_read(ADDR_COUNT, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL zero_b_count got %0d exp 0", d); end
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== 32'd9) begin n_fail++; $display("FAIL zero_b_result got %0d exp 9", d); end
        bus_write(ADDR_B, 0);
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        n_checks++;
        if (polls != 2 || d !== 32'h5) begin n_fail++; $display("FAIL zero_both_status got %h polls %0d exp 5 polls 2", d, polls); end
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL zero_both_result got %0d exp 0", d); end
    endtask

    task automatic test_busy_writes;
        logic [31:0] d;
        int polls;
        int unsigned g, n;
        bus_write(ADDR_A, 255);
        bus_write(ADDR_B, 1);
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_A, 6);
        bus_write(ADDR_B, 4);
        bus_read(ADDR_A, d);
        n_checks++;
        if (d !== 32'd6) begin n_fail++; $display("FAIL shadow_during_run got %0d exp 6", d); end
        poll_done(polls, d);
        n_checks++;
        if (polls != 252 || d !== 32'h1) begin n_fail++; $display("FAIL long_run_done got %h polls %0d exp 1 polls 252", d, polls); end
        bus_read(ADDR_COUNT, d);
        n_checks++;
        if (d !== 32'd254) begin n_fail++; $display("FAIL long_run_count got %0d exp 254", d); end
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL long_run_result got %0d exp 1", d); end
        model(6, 4, g, n);
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== g) begin n_fail++; $display("FAIL restart_result got %0d exp %0d", d, g); end
        bus_read(ADDR_COUNT, d);
        n_checks++;
        if (d !== n) begin n_fail++; $display("FAIL restart_count got %0d exp %0d", d, n); end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        int unsigned g, n;
        model(6, 4, g, n);
        bus_write(ADDR_A, 1000);
        bus_write(ADDR_B, 1);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        bus_write(ADDR_CTRL, 32'h9);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL abort_status got %h exp 0", d); end
        repeat (5) @(negedge clk);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL abort_stays_idle got %h exp 0", d); end
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== g) begin n_fail++; $display("FAIL abort_keeps_result got %0d exp %0d", d, g); end
        bus_read(ADDR_COUNT, d);
        n_checks++;
        if (d !== n) begin n_fail++; $display("FAIL abort_keeps_count got %0d exp %0d", d, n); end
        bus_write(ADDR_A, 200);
        bus_write(ADDR_B, 3);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            bus_read(3'(a), d);
            n_checks++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_reg%0d got %h exp 0", a, d); end
        end
        repeat (100) @(negedge clk);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_reset_no_done got %h exp 0", d); end
    endtask

    task automatic test_clear;
        logic [31:0] d;
        int polls;
        int unsigned g, n;
        model(21, 14, g, n);
        bus_write(ADDR_A, 21);
        bus_write(ADDR_B, 14);
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== g) begin n_fail++; $display("FAIL clear_read_result got %0d exp %0d", d, g); end
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL clear_by_read got %h exp 0", d); end
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        bus_write(ADDR_CTRL, 32'h4);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL clear_by_ctrl got %h exp 0", d); end
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        bus_write(ADDR_CTRL, 32'h5);
        bus_read(ADDR_STATUS, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL start_beats_clear got %h exp 2", d); end
        poll_done(polls, d);
        bus_read(ADDR_RESULT, d);
        n_checks++;
        if (d !== g) begin n_fail++; $display("FAIL start_clear_result got %0d exp %0d", d, g); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        int polls;
        bus_write(ADDR_A, 21);
        bus_write(ADDR_B, 14);
        bus_write(ADDR_CTRL, 32'h3);
        poll_done(polls, d);
`ifdef GCD_ACCEL_IRQ_EN
        n_checks++;
        if (d !== 32'h9) begin n_fail++; $display("FAIL irq_status got %h exp 9", d); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_high got %b exp 1", irq); end
        bus_read(ADDR_RESULT, d);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_low_after_read got %b exp 0", irq); end
        bus_write(ADDR_CTRL, 32'h1);
        poll_done(polls, d);
        n_checks++;
        if (irq !== 1'b0 || d !== 32'h1) begin n_fail++; $display("FAIL irq_disabled got irq %b status %h exp 0 and 1", irq, d); end
`else
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL no_irq_status got %h exp 1", d); end
`endif
        bus_read(ADDR_RESULT, d);
    endtask

    task automatic test_random;
        logic [31:0] d;
        int polls;
        int unsigned a, b, g, n;
        for (int i = 0; i < 24; i++) begin
            a = (i % 8 == 0) ? 0 : $urandom_range(1, 255);
            b = (i % 11 == 3) ? 0 : $urandom_range(1, 255);
            if (i == 5) b = a;
            model(a, b, g, n);
            bus_write(ADDR_A, a);
            bus_write(ADDR_B, b);
            bus_write(ADDR_CTRL, 32'h1);
            poll_done(polls, d);
            n_checks++;
            if (polls != int'(n) + 2 || d !== ((a == 0 && b == 0) ? 32'h5 : 32'h1)) begin
                n_fail++; $display("FAIL rand%0d_timing a=%0d b=%0d got status %h polls %0d exp polls %0d", i, a, b, d, polls, n + 2);
            end
            bus_read(ADDR_COUNT, d);
            n_checks++;
            if (d !== n) begin n_fail++; $display("FAIL rand%0d_count a=%0d b=%0d got %0d exp %0d", i, a, b, d, n); end
            bus_read(ADDR_RESULT, d);
            n_checks++;
            if (d !== g) begin n_fail++; $display("FAIL rand%0d_result a=%0d b=%0d got %0d exp %0d", i, a, b, d, g); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_map;
        test_basic;
        test_zero;
        test_busy_writes;
        test_abort;
        test_clear;
        test_irq;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
